// File: rtl/alu_exec_if.sv
// Handshake bus between the execute-stage producer/consumer and alu_exec_unit.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    // ALU side
    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );

    // Pipeline side
    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides.
// Non-shift ops finish in one cycle; shifts run one bit per cycle unless
// ALU_BARREL_SHIFT_EN is defined, in which case every op takes one cycle.
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;
    logic               out_valid_q, out_valid_d;

    logic [SHAMT_W-1:0] shamt;
    logic               in_ready_c;
    logic               accept_c;
    logic [WIDTH-1:0]   op_res_c;
    logic               op_ill_c;

`ifndef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [3:0]         op_q, op_d;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
    endfunction

    // One-bit step of the serial shifter.
    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] v);
        case (op)
            OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
            OP_SRL:  return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-2:0], 1'b0};
        endcase
    endfunction
`endif

    assign shamt      = bus.src_b[SHAMT_W-1:0];
    assign in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

    // Single-cycle result of the presented op (serial shifts: first bit only).
    always_comb begin
        op_res_c = '0;
        op_ill_c = 1'b0;
        case (bus.alu_control)
            OP_ADD:  op_res_c = bus.src_a + bus.src_b;
            OP_SUB:  op_res_c = bus.src_a - bus.src_b;
            OP_AND:  op_res_c = bus.src_a & bus.src_b;
            OP_OR:   op_res_c = bus.src_a | bus.src_b;
            OP_XOR:  op_res_c = bus.src_a ^ bus.src_b;
            OP_SLT:  op_res_c = WIDTH'($signed(bus.src_a) < $signed(bus.src_b));
            OP_SLTU: op_res_c = WIDTH'(bus.src_a < bus.src_b);
`ifdef ALU_BARREL_SHIFT_EN
            OP_SRA:  op_res_c = $unsigned($signed(bus.src_a) >>> shamt);
            OP_SRL:  op_res_c = bus.src_a >> shamt;
            OP_SLL:  op_res_c = bus.src_a << shamt;
`else
            OP_SRA, OP_SRL, OP_SLL:
                op_res_c = (shamt == '0) ? bus.src_a
                                         : shift_one(bus.alu_control, bus.src_a);
`endif
            default: op_ill_c = 1'b1;
        endcase
    end

    // Next-state and output-register logic.
    // The accept cycle already performs the first shift step, so a shift of
    // N bits spends N-1 cycles in SHIFT and presents its result N cycles
    // after acceptance (shamt 0 and 1 finish in one cycle).
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
`ifndef ALU_BARREL_SHIFT_EN
        sh_d        = sh_q;
        count_d     = count_q;
        op_d        = op_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if ((state_q == DONE) && bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept_c) begin
`ifndef ALU_BARREL_SHIFT_EN
                    if (is_shift_op(bus.alu_control) && (shamt > SHAMT_W'(1))) begin
                        state_d     = SHIFT;
                        out_valid_d = 1'b0;
                        sh_d        = shift_one(bus.alu_control, bus.src_a);
                        count_d     = shamt - SHAMT_W'(1);
                        op_d        = bus.alu_control;
                    end else
`endif
                    begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = op_res_c;
                        zero_d      = (op_res_c == '0);
                        illegal_d   = op_ill_c;
                    end
                end
            end
            SHIFT: begin
`ifndef ALU_BARREL_SHIFT_EN
                sh_d    = shift_one(op_q, sh_q);
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = shift_one(op_q, sh_q);
                    zero_d      = (shift_one(op_q, sh_q) == '0);
                    illegal_d   = 1'b0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifndef ALU_BARREL_SHIFT_EN
    // Serial shifter working registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '0;
            count_q <= '0;
            op_q    <= '0;
        end else begin
            sh_q    <= sh_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: transaction-level reference model
// (result + expected completion cycle) compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_alu_exec_unit;

    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_exec_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state: one outstanding op and the cycle it completes.
    int               cyc        = 0;
    bit               m_valid    = 1'b0;
    int               m_ready_at = 0;
    logic [WIDTH-1:0] m_res      = '0;
    logic             m_ill      = 1'b0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result of an op: {illegal, result}.
    function automatic logic [WIDTH:0] ref_op(input logic [3:0] code,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (code)
            4'b0000: return {1'b0, a + b};
            4'b0001: return {1'b0, a - b};
            4'b0010: return {1'b0, a & b};
            4'b0011: return {1'b0, a | b};
            4'b0101: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            4'b1011: return {1'b0, (a < b) ? 32'd1 : 32'd0};
            4'b0111: return {1'b0, a ^ b};
            4'b1000: return {1'b0, $unsigned($signed(a) >>> sh)};
            4'b1001: return {1'b0, a >> sh};
            4'b1010: return {1'b0, a << sh};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] code, input logic [WIDTH-1:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (code == 4'b1000 || code == 4'b1001 || code == 4'b1010)
            return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
        return 1;
`endif
    endfunction

    // Model update on each active edge, from the bench's own inputs.
    always @(posedge clk) begin
        logic [WIDTH:0] r;
        bit done, rdy;
        if (reset) begin
            m_valid = 1'b0;
        end else begin
            done = m_valid && (cyc >= m_ready_at);
            rdy  = !m_valid || (done && bus.out_ready);
            if (done && bus.out_ready) m_valid = 1'b0;
            if (bus.in_valid && rdy) begin
                r          = ref_op(bus.alu_control, bus.src_a, bus.src_b);
                m_valid    = 1'b1;
                m_ill      = r[WIDTH];
                m_res      = r[WIDTH-1:0];
                m_ready_at = cyc + ref_lat(bus.alu_control, bus.src_b);
            end
        end
        cyc++;
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        bit done, rdy;
        if (chk_en) begin
            done = m_valid && (cyc >= m_ready_at);
            rdy  = !m_valid || (done && bus.out_ready);
            chk("out_valid", 32'(bus.out_valid), 32'(done));
            chk("in_ready", 32'(bus.in_ready), 32'(rdy));
            if (done) begin
                chk("result", bus.result, m_res);
                chk("zero", 32'(bus.zero), 32'(m_res == '0));
                chk("illegal", 32'(bus.illegal), 32'(m_ill));
            end
        end
    end

    // Drive one cycle of inputs; returns just after the following negedge.
    task automatic drive(input logic rst, input logic v, input logic [3:0] code,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ordy);
        reset           = rst;
        bus.in_valid    = v;
        bus.alu_control = code;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.out_ready   = ordy;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 1'b0, 4'b0000, '0, '0, ordy);
    endtask

    logic [3:0] legal [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101,
                               4'b1011, 4'b0111, 4'b1000, 4'b1001, 4'b1010};

    initial begin
        logic [3:0] code;
        bus.in_valid    = 1'b0;
        bus.alu_control = '0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        bus.out_ready   = 1'b0;

        drive(1'b1, 1'b0, 4'b0000, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 4'b0000, '0, '0, 1'b0);
        chk_en = 1'b1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst result", bus.result, 32'h0);
        chk("rst zero", 32'(bus.zero), 32'd0);
        chk("rst illegal", 32'(bus.illegal), 32'd0);

        // add wrapping to zero
        drive(1'b0, 1'b1, 4'b0000, 32'h0000_0005, 32'hFFFF_FFFB, 1'b1);
        chk("add valid", 32'(bus.out_valid), 32'd1);
        chk("add result", bus.result, 32'h0);
        chk("add zero", 32'(bus.zero), 32'd1);

        // slt then sltu back-to-back
        drive(1'b0, 1'b1, 4'b0101, 32'hFFFF_FFFF, 32'h1, 1'b1);
        chk("slt result", bus.result, 32'h1);
        drive(1'b0, 1'b1, 4'b1011, 32'hFFFF_FFFF, 32'h1, 1'b1);
        chk("sltu result", bus.result, 32'h0);
        chk("sltu zero", 32'(bus.zero), 32'd1);

        // sra by 3 (upper shamt bits ignored)
        drive(1'b0, 1'b1, 4'b1000, 32'h8000_0000, 32'h0000_0023, 1'b1);
`ifdef ALU_BARREL_SHIFT_EN
        chk("sra valid", 32'(bus.out_valid), 32'd1);
        chk("sra result", bus.result, 32'hF000_0000);
`else
        chk("sra busy1", 32'(bus.in_ready), 32'd0);
        idle(1'b1);
        chk("sra busy2", 32'(bus.in_ready), 32'd0);
        chk("sra not valid", 32'(bus.out_valid), 32'd0);
        idle(1'b1);
        chk("sra valid", 32'(bus.out_valid), 32'd1);
        chk("sra result", bus.result, 32'hF000_0000);
`endif

        // or held under backpressure, then and accepted back-to-back
        drive(1'b0, 1'b1, 4'b0011, 32'h0F0F_0000, 32'h0000_F0F0, 1'b1);
        chk("or result", bus.result, 32'h0F0F_F0F0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("or held", bus.result, 32'h0F0F_F0F0);
        end
        drive(1'b0, 1'b1, 4'b0010, 32'h0000_00FF, 32'h0000_0F0F, 1'b1);
        chk("b2b valid", 32'(bus.out_valid), 32'd1);
        chk("b2b result", bus.result, 32'h0000_000F);
        idle(1'b1);

        // illegal code
        drive(1'b0, 1'b1, 4'b0100, $urandom, $urandom, 1'b1);
        chk("ill valid", 32'(bus.out_valid), 32'd1);
        chk("ill flag", 32'(bus.illegal), 32'd1);
        chk("ill result", bus.result, 32'h0);
        chk("ill zero", 32'(bus.zero), 32'd1);
        idle(1'b1);

        // reset in the middle of a long sll, then a sub
        drive(1'b0, 1'b1, 4'b1010, 32'h1, 32'd20, 1'b1);
        idle(1'b1);
        drive(1'b1, 1'b0, 4'b0000, '0, '0, 1'b1);
        chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid rst result", bus.result, 32'h0);
        drive(1'b0, 1'b1, 4'b0001, 32'd7, 32'd9, 1'b1);
        chk("sub result", bus.result, 32'hFFFF_FFFE);
        idle(1'b1);

        // randomized traffic with backpressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) code = 4'($urandom);
            else                           code = legal[$urandom_range(0, 9)];
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), code,
                  $urandom, $urandom, ($urandom_range(0, 3) != 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
